fetch_stage: RTL and testbench

//  Instruction-fetch stage; the producer feeding the Fetch->Decode pipeline register (InstrF/PCF/PCPlus4F).

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FETCH_MISALIGN_TRAP_EN adds the terminal HALT state to the state encoding.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_HOLD = 3'd2,
    ST_DROP = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    ST_HALT = 3'd4
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port: req/gnt handshake, rvalid/rdata response.
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, feeds the F/D register.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect raises sticky misalign_o and halts fetch.
//
// state | meaning
// IDLE  | request asserted for pc_q, nothing outstanding
// WAIT  | one request outstanding, waiting for rvalid
// HOLD  | response captured in the hold buffer while StallF=1
// DROP  | outstanding response belongs to a squashed path, discard it
// HALT  | misaligned redirect trapped, only rst leaves (trap build only)
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               PCSrcE,
  input  logic [31:0]        PCTargetE,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] InstrF,
  output logic [31:0]        PCF,
  output logic [31:0]        PCPlus4F,
  output logic               ValidF,
  output logic               misalign_o
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, req_pc_q, hold_pc_q;
  logic [INSTR_W-1:0] hold_instr_q;
  logic [31:0]        target;
  logic               halted, redirect, fire;
  logic               deliver_mem, deliver_hold, capture, bubble;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic bad_target;
  logic misalign_q;

  assign target     = PCTargetE;
  assign bad_target = |PCTargetE[1:0];
  assign halted     = (state_q == ST_HALT);
`else
  assign target     = PCTargetE & ~32'h3;
  assign halted     = 1'b0;
`endif

  // a redirect squashes everything in flight, even under a stall
  assign redirect       = PCSrcE & ~halted;
  assign fire           = imem.imem_req & imem.imem_gnt;
  assign imem.imem_addr = pc_q;
  assign bubble         = halted | redirect | (~StallF & ~deliver_mem & ~deliver_hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (fire) state_d = ST_WAIT;
      ST_WAIT: begin
        if (redirect)
          state_d = imem.imem_rvalid ? ST_IDLE : ST_DROP;
        else if (imem.imem_rvalid)
          state_d = StallF ? ST_HOLD : (fire ? ST_WAIT : ST_IDLE);
      end
      ST_HOLD: if (redirect || !StallF) state_d = ST_IDLE;
      // a redirect here only moves pc_q; the stale response still has to be absorbed
      ST_DROP: if (imem.imem_rvalid) state_d = ST_IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (redirect && bad_target) state_d = ST_HALT;
`endif
  end

  always_comb begin
    imem.imem_req = 1'b0;
    deliver_mem   = 1'b0;
    deliver_hold  = 1'b0;
    capture       = 1'b0;
    unique case (state_q)
      ST_IDLE: imem.imem_req = ~redirect;
      ST_WAIT: begin
        if (imem.imem_rvalid && !redirect) begin
          if (StallF) begin
            capture = 1'b1;
          end else begin
            deliver_mem   = 1'b1;
            imem.imem_req = 1'b1;
          end
        end
      end
      ST_HOLD: deliver_hold = ~StallF & ~redirect;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= '0;
      InstrF       <= NOP_INSTR;
      PCF          <= 32'h0;
      PCPlus4F     <= 32'h0;
      ValidF       <= 1'b0;
    end else begin
      if (redirect)  pc_q <= target;
      else if (fire) pc_q <= pc_q + 32'd4;

      if (fire) req_pc_q <= pc_q;

      if (capture) begin
        hold_instr_q <= imem.imem_rdata;
        hold_pc_q    <= req_pc_q;
      end

      // PCF/PCPlus4F keep the last real instruction's PC across bubbles
      if (deliver_mem) begin
        InstrF   <= imem.imem_rdata;
        PCF      <= req_pc_q;
        PCPlus4F <= req_pc_q + 32'd4;
        ValidF   <= 1'b1;
      end else if (deliver_hold) begin
        InstrF   <= hold_instr_q;
        PCF      <= hold_pc_q;
        PCPlus4F <= hold_pc_q + 32'd4;
        ValidF   <= 1'b1;
      end else if (bubble) begin
        InstrF <= NOP_INSTR;
        ValidF <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          misalign_q <= 1'b0;
    else if (redirect && bad_target)  misalign_q <= 1'b1;
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random memory latency/grants, stalls and redirects against a
// program-order model; expected fetches are queued at grant time and popped by a monitor.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        ValidF, misalign_o;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (imem_bus),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .ValidF    (ValidF),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  exp_t        exp_q[$];
  logic [31:0] model_pc = RST_PC;
  int          v_cyc[$];
  logic [31:0] v_pc[$];
  int          cyc = 0;

  // memory + stimulus knobs
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  int          p_gnt = 100, p_stall = 0, p_redir = 0, lat_min = 1, lat_max = 1;
  bit          f_redir = 1'b0;
  logic [31:0] f_target = 32'h0;
  bit          watch = 1'b0;
  logic [31:0] after_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = 32'hFFFF_FFF8;
      1:       t = 32'h0000_1000 + ($urandom_range(0, 255) << 2);
      2:       t = 32'hFFFF_FFFC;
      default: t = $urandom;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  // Called at posedge+1; drives one cycle of inputs and records its effect on the model.
  task automatic drive_cycle();
    bit rv, g;
    #1;
    StallF = ($urandom_range(0, 99) < p_stall);
    if (f_redir) begin
      PCSrcE    = 1'b1;
      PCTargetE = f_target;
      f_redir   = 1'b0;
      watch     = 1'b1;
    end else begin
      PCSrcE    = ($urandom_range(0, 99) < p_redir);
      PCTargetE = pick_target();
    end
    rv = 1'b0;
    if (mem_busy) begin
      if (mem_cnt > 1) mem_cnt--;
      else rv = 1'b1;
    end
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rv ? mem_word(mem_addr) : $urandom;
    #1;
    if (imem_bus.imem_req && mem_busy && !rv) begin
      n_cmp++; n_err++;
      $display("FAIL second_outstanding: got req=1 with a response pending, required req=0");
    end
    if (PCSrcE) chk("req_on_redirect", imem_bus.imem_req, 0);
    g = imem_bus.imem_req && ($urandom_range(0, 99) < p_gnt);
    imem_bus.imem_gnt = g;
    if (g) begin
      chk("req_addr", imem_bus.imem_addr, model_pc);
      exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
      if (watch) begin
        after_addr = imem_bus.imem_addr;
        watch      = 1'b0;
      end
    end
    if (PCSrcE) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      model_pc = PCTargetE;
`else
      model_pc = PCTargetE & ~32'h3;
`endif
    end
    if (rv) mem_busy = 1'b0;
    if (g) begin
      mem_busy = 1'b1;
      mem_addr = imem_bus.imem_addr;
      mem_cnt  = $urandom_range(lat_min, lat_max);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: checks what the F/D-facing outputs show after each edge
  logic [31:0] last_instr = NOP_INSTR, last_pcf = 32'h0, last_pcp4 = 32'h0;
  logic        last_valid = 1'b0;

  initial begin
    bit s_st, s_rd, s_rst;
    exp_t e;
    forever begin
      @(posedge clk);
      s_st = StallF; s_rd = PCSrcE; s_rst = rst;
      #1;
      if (!s_rst) begin
        cyc++;
        if (s_rd) begin
          chk("redirect_bubble_valid", ValidF, 0);
          chk("redirect_bubble_instr", InstrF, NOP_INSTR);
        end else if (s_st) begin
          chk("stall_instr", InstrF, last_instr);
          chk("stall_pcf", PCF, last_pcf);
          chk("stall_valid", ValidF, last_valid);
        end else if (ValidF) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb_underflow: got valid PCF=%h, required a bubble", PCF);
          end else begin
            e = exp_q.pop_front();
            chk("out_pcf", PCF, e.pc);
            chk("out_instr", InstrF, e.instr);
            chk("out_pcplus4", PCPlus4F, e.pc + 32'd4);
            v_cyc.push_back(cyc);
            v_pc.push_back(PCF);
          end
        end else begin
          chk("bubble_instr", InstrF, NOP_INSTR);
          chk("bubble_pcf", PCF, last_pcf);
        end
      end
      last_instr = InstrF; last_pcf = PCF; last_pcp4 = PCPlus4F; last_valid = ValidF;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx0, nv;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ValidF, 0);
    chk("rst_instr", InstrF, NOP_INSTR);
    chk("rst_pcf", PCF, 0);
    chk("rst_pcplus4", PCPlus4F, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_req", imem_bus.imem_req, 1);
    chk("rst_addr", imem_bus.imem_addr, RST_PC);
    rst = 1'b0;

    // zero-wait memory: one instruction per cycle from cycle 2
    run(6);
    chk("p1_count_ok", v_pc.size() >= 3, 1);
    if (v_pc.size() >= 3) begin
      chk("p1_first_cycle", v_cyc[0], 2);
      chk("p1_pc0", v_pc[0], 32'h100);
      chk("p1_pc1", v_pc[1], 32'h104);
      chk("p1_pc2", v_pc[2], 32'h108);
      chk("p1_third_cycle", v_cyc[2], 4);
    end

    // two-cycle latency: valid every other cycle
    lat_min = 2; lat_max = 2;
    idx0 = v_cyc.size();
    run(20);
    chk("p2_count_ok", (v_cyc.size() - idx0) >= 8, 1);
    for (int i = idx0 + 2; i < v_cyc.size(); i++)
      chk("p2_gap", v_cyc[i] - v_cyc[i-1], 2);

    // random traffic
    p_gnt = 70; p_stall = 30; p_redir = 8; lat_min = 1; lat_max = 4;
    nv = v_cyc.size();
    run(3000);
    chk("p3_progress", (v_cyc.size() - nv) > 200, 1);

    // park an instruction in the hold buffer, then redirect while still stalled
    p_gnt = 100; p_stall = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    run(10);
    f_redir = 1'b1; f_target = 32'h0000_0600;
    run(1);
    p_stall = 0;
    run(10);
    chk("hold_redirect_addr", after_addr, 32'h600);

    // PC wraps modulo 2^32
    f_redir = 1'b1; f_target = 32'hFFFF_FFF8;
    run(10);
    chk("wrap_addr", after_addr, 32'hFFFF_FFF8);

    // misaligned redirect
    f_redir = 1'b1; f_target = 32'h0000_0402;
`ifdef FETCH_MISALIGN_TRAP_EN
    drive_cycle();
    @(posedge clk);
    #1;
    chk("trap_misalign", misalign_o, 1);
    repeat (20) begin
      drive_cycle();
      chk("trap_no_req", imem_bus.imem_req, 0);
      @(posedge clk);
      #1;
    end
    chk("trap_misalign_sticky", misalign_o, 1);
`else
    run(10);
    chk("misalign_addr", after_addr, 32'h400);
    chk("misalign_flag", misalign_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
